move_cmd_gen: RTL

//  Generates move commands for the 2048 game FSM from four raw push-buttons.
//  Per button: 2-flop sync, debounce, press-edge detect. Captures one

---
 rtl/move_cmd_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 54 +++++
 rtl/move_cmd_gen.sv | 139 +++++++++++++
 3 files changed

// File: rtl/move_cmd_pkg.sv
// Shared definitions for the move command generator: one-hot command codes,
// FSM encodings and the fixed UP>DOWN>LEFT>RIGHT press priority.
package move_cmd_pkg;

  localparam logic [3:0] CMD_NONE  = 4'b0000;
  localparam logic [3:0] CMD_UP    = 4'b0001;
  localparam logic [3:0] CMD_DOWN  = 4'b0010;
  localparam logic [3:0] CMD_LEFT  = 4'b0100;
  localparam logic [3:0] CMD_RIGHT = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    LOCK = 2'b10
  } state_t;

  // Bit order of p matches the command codes: [0]=up [1]=down [2]=left [3]=right.
  function automatic logic [3:0] prio_sel(input logic [3:0] p);
    if (p[0])      return CMD_UP;
    else if (p[1]) return CMD_DOWN;
    else if (p[2]) return CMD_LEFT;
    else if (p[3]) return CMD_RIGHT;
    else           return CMD_NONE;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchroniser, stability counter and press-edge detect.
// The debounced level is exported only when AUTO_REPEAT_EN is defined.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic btn,
`ifdef AUTO_REPEAT_EN
  output logic level,
`endif
  output logic press
);

  localparam int unsigned CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  logic          sync0;
  logic          sync1;
  logic          db;
  logic          db_q;
  logic [CW-1:0] cnt;

  // Counter runs only while the synced input disagrees with the debounced level.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      db    <= 1'b0;
      db_q  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
      db_q  <= db;
      if (sync1 != db) begin
        if (cnt == CW'(DB_CYCLES - 1)) begin
          db  <= sync1;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = db & ~db_q;

`ifdef AUTO_REPEAT_EN
  assign level = db;
`endif

endmodule

// File: rtl/move_cmd_gen.sv
// Turns four raw buttons into one-cycle move pulses for the 2048 game FSM.
// Optional AUTO_REPEAT_EN: re-issues a held button after RPT_DELAY, then every RPT_PERIOD.
//
//  state | meaning
//  IDLE  | waiting for a press (or repeat)
//  PEND  | command captured, waiting for ready
//  LOCK  | pulse issued, waiting for ready to drop
module move_cmd_gen
  import move_cmd_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = 500000,
  parameter int unsigned RPT_DELAY  = 25000000,
  parameter int unsigned RPT_PERIOD = 10000000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        BtnU,
  input  logic        BtnD,
  input  logic        BtnL,
  input  logic        BtnR,
  input  logic        ready,
  output logic        up,
  output logic        down,
  output logic        left,
  output logic        right,
  output logic        cmd_pending,
  output logic [15:0] move_count
);

  if (DB_CYCLES < 2 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_cfg
    $error("move_cmd_gen: DB_CYCLES must be >= 2 and repeat intervals >= 1");
  end

  logic [3:0] btn_raw;
  logic [3:0] press;
  logic [3:0] cap_cmd;
  logic [3:0] cmd;
  logic [3:0] pulse;
  state_t     state;

  assign btn_raw = {BtnR, BtnL, BtnD, BtnU};

`ifdef AUTO_REPEAT_EN
  logic [3:0] db_lvl;
`endif

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .btn     (btn_raw[i]),
`ifdef AUTO_REPEAT_EN
      .level   (db_lvl[i]),
`endif
      .press   (press[i])
    );
  end

`ifdef AUTO_REPEAT_EN
  logic [3:0]  rpt_btn;
  logic [31:0] rpt_cnt;
  logic        rpt_held;
  logic        rpt_fire;

  assign rpt_held = |(rpt_btn & db_lvl);
  assign rpt_fire = rpt_held && (rpt_cnt == 32'd0);

  // Tracking starts on a fresh captured press; the timer keeps running outside IDLE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rpt_btn <= CMD_NONE;
      rpt_cnt <= 32'd0;
    end else if (state == IDLE && press != 4'b0000) begin
      rpt_btn <= prio_sel(press);
      rpt_cnt <= 32'(RPT_DELAY - 1);
    end else if (rpt_btn != CMD_NONE) begin
      if (!rpt_held) begin
        rpt_btn <= CMD_NONE;
        rpt_cnt <= 32'd0;
      end else if (rpt_cnt == 32'd0) begin
        rpt_cnt <= 32'(RPT_PERIOD - 1);
      end else begin
        rpt_cnt <= rpt_cnt - 32'd1;
      end
    end
  end
`endif

  always_comb begin
    cap_cmd = prio_sel(press);
`ifdef AUTO_REPEAT_EN
    if (cap_cmd == CMD_NONE && rpt_fire) cap_cmd = rpt_btn;
`endif
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      cmd         <= CMD_NONE;
      pulse       <= CMD_NONE;
      cmd_pending <= 1'b0;
      move_count  <= 16'd0;
    end else begin
      pulse <= CMD_NONE;
      case (state)
        IDLE: begin
          if (cap_cmd != CMD_NONE) begin
            cmd         <= cap_cmd;
            cmd_pending <= 1'b1;
            state       <= PEND;
          end
        end
        PEND: begin
          if (ready) begin
            pulse       <= cmd;
            cmd_pending <= 1'b0;
            move_count  <= move_count + 16'd1;
            state       <= LOCK;
          end
        end
        LOCK: begin
          if (!ready) state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          cmd_pending <= 1'b0;
        end
      endcase
    end
  end

  assign up    = pulse[0];
  assign down  = pulse[1];
  assign left  = pulse[2];
  assign right = pulse[3];

endmodule
